// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring-counter code checker.
// Helpers work on a zero-extended MAX_W vector so any WIDTH up to MAX_W can use them.
package ring_pkg;

    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_IW = $clog2(MAX_W);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_e;

    // Rotate-right successor of a w-bit code held in the low bits of code.
    function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] code, input int unsigned w);
        logic [MAX_W-1:0] r;
        r = code >> 1;
        r[MAX_IW'(w - 1)] = code[0];
        return r;
    endfunction

    function automatic int unsigned onehot_idx(input logic [MAX_W-1:0] code);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (code[MAX_IW'(i)]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [MAX_W-1:0] code);
        return $countones(code) == 1;
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot legality check and binary decode of a ring code.
module ring_onehot_decode
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] code_i,
    output logic             legal_c_o,
    output logic [IDX_W-1:0] idx_c_o
);

    logic [MAX_W-1:0] code_ext;

    assign code_ext  = MAX_W'(code_i);
    assign legal_c_o = is_onehot(code_ext);
    // Illegal codes decode to index 0 so downstream never sees a stale position.
    assign idx_c_o   = legal_c_o ? IDX_W'(onehot_idx(code_ext)) : '0;

endmodule

// File: rtl/ring_code_checker.sv
// Receiver for a rotate-right one-hot ring code: decodes the phase, flags
// illegal codes and broken successions, and tracks lock via hunt/verify/locked.
module ring_code_checker
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned IDX_W      = $clog2(WIDTH),
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_code,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 code_err,
    output logic                 seq_err,
    output logic                 wrap,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);

    state_e                 state_q;
    logic [WIDTH-1:0]       prev_q;
    logic                   prev_valid_q;
    logic [GOOD_W-1:0]      good_cnt_q;
    logic [BAD_W-1:0]       bad_cnt_q;
    logic                   out_valid_q;
    logic [IDX_W-1:0]       out_idx_q;
    logic                   code_err_q;
    logic                   seq_err_q;
    logic                   wrap_q;
    logic                   locked_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic                   legal_c;
    logic [IDX_W-1:0]       idx_c;
    logic [WIDTH-1:0]       succ_c;
    logic                   seq_ok_c;
    logic                   seq_bad_c;
    logic                   err_c;
    logic [GOOD_W-1:0]      good_inc_c;
    logic [BAD_W-1:0]       bad_inc_c;

    ring_onehot_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .code_i    (in_code),
        .legal_c_o (legal_c),
        .idx_c_o   (idx_c)
    );

    assign succ_c     = WIDTH'(rotr(MAX_W'(prev_q), WIDTH));
    assign seq_ok_c   = legal_c && prev_valid_q && (in_code == succ_c);
    assign seq_bad_c  = legal_c && prev_valid_q && !seq_ok_c;
    assign err_c      = !legal_c || seq_bad_c;
    assign good_inc_c = good_cnt_q + GOOD_W'(1);
    assign bad_inc_c  = bad_cnt_q + BAD_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            code_err_q   <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q <= in_valid;
            code_err_q  <= in_valid && !legal_c;
            seq_err_q   <= in_valid && seq_bad_c;
            wrap_q      <= in_valid && seq_ok_c && in_code[0];
            if (in_valid) begin
                out_idx_q <= idx_c;
                if (err_c && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                unique case (state_q)
                    HUNT: begin
                        if (legal_c) begin
                            prev_q       <= in_code;
                            prev_valid_q <= 1'b1;
                            good_cnt_q   <= '0;
                            state_q      <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (seq_ok_c) begin
                            prev_q <= in_code;
                            if (good_inc_c == GOOD_W'(LOCK_CNT)) begin
                                good_cnt_q <= '0;
                                bad_cnt_q  <= '0;
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                            end else begin
                                good_cnt_q <= good_inc_c;
                            end
                        end else if (legal_c) begin
                            prev_q     <= in_code;
                            good_cnt_q <= '0;
                        end else begin
                            prev_valid_q <= 1'b0;
                            state_q      <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (seq_ok_c) begin
                            prev_q    <= in_code;
                            bad_cnt_q <= '0;
                        end else begin
                            // Legal mismatch resyncs; illegal code flywheels the expected phase.
                            prev_q <= legal_c ? in_code : succ_c;
                            if (bad_inc_c == BAD_W'(UNLOCK_CNT)) begin
                                bad_cnt_q    <= '0;
                                prev_valid_q <= 1'b0;
                                state_q      <= HUNT;
                                locked_q     <= 1'b0;
                            end else begin
                                bad_cnt_q <= bad_inc_c;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign code_err  = code_err_q;
    assign seq_err   = seq_err_q;
    assign wrap      = wrap_q;
    assign locked    = locked_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ring_code_checker.sv
// Directed bench for ring_code_checker (WIDTH=4, LOCK_CNT=3, UNLOCK_CNT=2, ERR_CNT_W=2).
module tb_ring_code_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_code;
    logic       out_valid;
    logic [1:0] out_idx;
    logic       code_err;
    logic       seq_err;
    logic       wrap;
    logic       locked;
    logic [1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    ring_code_checker #(
        .WIDTH      (4),
        .IDX_W      (2),
        .LOCK_CNT   (3),
        .UNLOCK_CNT (2),
        .ERR_CNT_W  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .code_err  (code_err),
        .seq_err   (seq_err),
        .wrap      (wrap),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample on the falling edge, then sample outputs just after the rising edge.
    task automatic step(input logic v, input logic [3:0] c);
        @(negedge clk);
        in_valid = v;
        in_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [1:0] idx,
                              input logic ce, input logic se, input logic wr,
                              input logic lk, input logic [1:0] ec);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".out_idx"},   32'(out_idx),   32'(idx));
        check({tag, ".code_err"},  32'(code_err),  32'(ce));
        check({tag, ".seq_err"},   32'(seq_err),   32'(se));
        check({tag, ".wrap"},      32'(wrap),      32'(wr));
        check({tag, ".locked"},    32'(locked),    32'(lk));
        check({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_code  = 4'b0000;
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        expect_out("rst", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Clean sequence through to lock and one wrap
        step(1'b1, 4'b0001); expect_out("t1.0", 1, 0, 0, 0, 0, 0, 0);
        step(1'b1, 4'b1000); expect_out("t1.1", 1, 3, 0, 0, 0, 0, 0);
        step(1'b1, 4'b0100); expect_out("t1.2", 1, 2, 0, 0, 0, 0, 0);
        step(1'b1, 4'b0010); expect_out("t1.3", 1, 1, 0, 0, 0, 1, 0);
        step(1'b1, 4'b0001); expect_out("t1.4", 1, 0, 0, 0, 1, 1, 0);

        // Illegal code flywheels 0001 -> 1000, so 0100 is the expected successor
        step(1'b1, 4'b0110); expect_out("t2.0", 1, 0, 1, 0, 0, 1, 1);
        step(1'b1, 4'b0100); expect_out("t2.1", 1, 2, 0, 0, 0, 1, 1);

        // Two illegal codes drop lock; next legal code re-enters verify cleanly
        step(1'b1, 4'b0000); expect_out("t3.0", 1, 0, 1, 0, 0, 1, 2);
        step(1'b1, 4'b0011); expect_out("t3.1", 1, 0, 1, 0, 0, 0, 3);
        step(1'b1, 4'b0100); expect_out("t3.2", 1, 2, 0, 0, 0, 0, 3);

        // Relock, then a gap of invalid cycles between two successions
        step(1'b1, 4'b0010); expect_out("t4.0", 1, 1, 0, 0, 0, 0, 3);
        step(1'b1, 4'b0001); expect_out("t4.1", 1, 0, 0, 0, 1, 0, 3);
        step(1'b1, 4'b1000); expect_out("t4.2", 1, 3, 0, 0, 0, 1, 3);
        step(1'b1, 4'b0100); expect_out("t4.3", 1, 2, 0, 0, 0, 1, 3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111); expect_out("t4.gap", 0, 2, 0, 0, 0, 1, 3);
        end
        step(1'b1, 4'b0010); expect_out("t4.4", 1, 1, 0, 0, 0, 1, 3);

        // Reset wins over a valid illegal sample
        reset = 1'b1;
        step(1'b1, 4'b0101); expect_out("t5.rst", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(1'b1, 4'b1000); expect_out("t5.hunt", 1, 3, 0, 0, 0, 0, 0);

        // Resync in verify, lock after three successions, then saturate err_cnt
        reset = 1'b1;
        step(1'b0, 4'b0000);
        reset = 1'b0;
        step(1'b1, 4'b0001); expect_out("t6.0", 1, 0, 0, 0, 0, 0, 0);
        step(1'b1, 4'b0100); expect_out("t6.1", 1, 2, 0, 1, 0, 0, 1);
        step(1'b1, 4'b0010); expect_out("t6.2", 1, 1, 0, 0, 0, 0, 1);
        step(1'b1, 4'b0001); expect_out("t6.3", 1, 0, 0, 0, 1, 0, 1);
        step(1'b1, 4'b1000); expect_out("t6.4", 1, 3, 0, 0, 0, 1, 1);
        step(1'b1, 4'b0000); expect_out("t6.5", 1, 0, 1, 0, 0, 1, 2);
        step(1'b1, 4'b1111); expect_out("t6.6", 1, 0, 1, 0, 0, 0, 3);
        step(1'b1, 4'b0000); expect_out("t6.7", 1, 0, 1, 0, 0, 0, 3);
        step(1'b1, 4'b0011); expect_out("t6.8", 1, 0, 1, 0, 0, 0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
